imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory of the pipelined core. It accepts a length-prefixed byte stream over a valid/ready handshake, for example from a UART receiver. It emits byte-wide little-endian writes to addresses 0..N-1, matching the instruction memory's byte layout (mem[PC]..mem[PC+3], LSB first). It holds the CPU in stall until the image is fully written, then releases it.

---
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: stream input, instruction-memory write port and loader status.
// The slave modport is the loader's view; the master modport is the view of
// whatever drives the byte stream and observes the writes.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_hold,
        input  load_done,
        input  load_error
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_hold,
        output load_done,
        output load_error
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory.
// Accepts LEN_LO, LEN_HI, then N data bytes, and writes them to byte
// addresses 0..N-1, one registered write per accepted byte. The CPU is held
// until the image is complete. Optional trailing XOR checksum byte is enabled
// by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 81
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHK    = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // State reached once all data bytes are in: a trailer check or completion.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHK;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rdy_q, rdy_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    logic        xfer_s;
    logic [15:0] len_full_s;

    assign xfer_s     = bus.rx_valid && rdy_q;
    assign len_full_s = {bus.rx_data, len_q[7:0]};

    // Next-state logic for the FSM, the write port and the status flags.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = S_LEN_HI;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    len_d[15:8] = bus.rx_data;
                    if (len_full_s > 16'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (len_full_s == 16'd0) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    we_d    = 1'b1;
                    addr_d  = {16'd0, cnt_q};
                    wdata_d = bus.rx_data;
                    cnt_d   = cnt_q + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.rx_data;
`endif
                    if (cnt_q == (len_q - 16'd1)) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer_s) begin
                    if (bus.rx_data == chk_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        rdy_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
`ifdef LOADER_CHECKSUM_EN
                (state_d == S_CHK) ||
`endif
                (state_d == S_DATA);
        err_d = (state_d == S_ERR);
`ifdef LOADER_CHECKSUM_EN
        // Completion is decided by the trailer byte, so release on that edge.
        done_d = (state_d == S_DONE);
`else
        // Release one cycle after entering S_DONE so the last write lands first.
        done_d = (state_q == S_DONE);
`endif
        hold_d = !done_d;
    end

    // State and output registers; reset cancels any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LEN_LO;
            len_q   <= 16'd0;
            cnt_q   <= 16'd0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 8'd0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign bus.rx_ready   = rdy_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.load_done  = done_q;
    assign bus.load_error = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized streams for imem_loader, checked
// against a stream-level model (length rule, address list, XOR trailer).
module tb_imem_loader;
    localparam int DEPTH = 81;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc = 0;
    int done_cyc = -1;
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          wc_q[$];

    // Cycle counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every memory write and the first cycle load_done is seen.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            wc_q.push_back(cyc);
        end
        if (bus.load_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_capture();
    endtask

    // Drive bytes; mode 0 = valid always, 1 = every other cycle, 2 = random.
    task automatic send(input bq_t s, input int mode, input int limit);
        int idx = 0;
        int idle = 0;
        int guard = 0;
        logic v;
        while (idx < s.size() && idx < limit && idle < 4 && guard < 3000) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.rx_valid = v;
            bus.rx_data  = s[idx];
            if (bus.rx_ready === 1'b1) begin
                idle = 0;
                if (v) idx++;
            end else begin
                idle++;
            end
            guard++;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        acc = idx;
    endtask

    function automatic bq_t mk(input int n, input bit good);
        bq_t s;
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            x ^= b;
            s.push_back(b);
        end
        if (CHK_EN) s.push_back(good ? x : (x ^ 8'h01));
        return s;
    endfunction

    // Run one stream and compare against the stream-level model.
    task automatic run_case(input string name, input bq_t s, input int mode);
        int n;
        bit bad;
        int exp_acc;
        int nw;
        logic [7:0] x;
        clear_capture();
        send(s, mode, 100000);
        repeat (3) @(negedge clk);
        n = int'({s[1], s[0]});
        bad = (n > DEPTH);
        nw = bad ? 0 : n;
        exp_acc = bad ? 2 : (CHK_EN ? n + 3 : n + 2);
        if (!bad && CHK_EN) begin
            x = 8'h00;
            for (int i = 0; i < n; i++) x ^= s[2 + i];
            bad = (s[2 + n] != x);
        end
        chk({name, ".accepted"}, 32'(acc), 32'(exp_acc));
        chk({name, ".nwrites"}, 32'(wa_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < wa_q.size(); i++) begin
            chk($sformatf("%s.addr%0d", name, i), wa_q[i], 32'(i));
            chk($sformatf("%s.data%0d", name, i), 32'(wd_q[i]), 32'(s[2 + i]));
        end
        chk({name, ".load_done"}, 32'(bus.load_done), 32'(!bad));
        chk({name, ".load_error"}, 32'(bus.load_error), 32'(bad));
        chk({name, ".cpu_hold"}, 32'(bus.cpu_hold), 32'(bad));
        chk({name, ".rx_ready"}, 32'(bus.rx_ready), 32'd0);
        if (mode == 0 && nw > 0 && wc_q.size() == nw)
            chk({name, ".burst"}, 32'(wc_q[nw - 1] - wc_q[0]), 32'(nw - 1));
        if (!CHK_EN && !bad && nw > 0 && wc_q.size() == nw)
            chk({name, ".release"}, 32'(done_cyc), 32'(wc_q[nw - 1] + 1));
    endtask

    initial begin
        bq_t s;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        chk("rst.rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst.mem_addr", bus.mem_addr, 32'd0);
        chk("rst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst.cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("rst.load_done", 32'(bus.load_done), 32'd0);
        chk("rst.load_error", 32'(bus.load_error), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel.rx_ready", 32'(bus.rx_ready), 32'd1);
        clear_capture();

        // 40-byte program, valid held high.
        s = mk(40, 1'b1);
        s[2] = 8'h03; s[3] = 8'ha3; s[4] = 8'h00; s[5] = 8'h00;
        s[38] = 8'hef; s[39] = 8'hf0; s[40] = 8'h5f; s[41] = 8'hfe;
        if (CHK_EN) begin
            s[42] = 8'h00;
            for (int i = 2; i < 42; i++) s[42] ^= s[i];
        end
        run_case("prog40", s, 0);

        // Oversize image is rejected.
        do_reset();
        s = {8'h52, 8'h00, 8'h11, 8'h22};
        run_case("n82", s, 0);

        // Four bytes with valid toggling.
        do_reset();
        s = {8'h04, 8'h00, 8'h13, 8'h03, 8'h13, 8'h00};
        if (CHK_EN) s.push_back(8'h13 ^ 8'h03 ^ 8'h13 ^ 8'h00);
        run_case("toggle4", s, 1);

        // Reset after 10 of 40 data bytes.
        do_reset();
        s = mk(40, 1'b1);
        send(s, 0, 12);
        #1 reset = 1'b1;
        #1;
        chk("mid.mem_we", 32'(bus.mem_we), 32'd0);
        chk("mid.mem_addr", bus.mem_addr, 32'd0);
        chk("mid.mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("mid.cpu_hold", 32'(bus.cpu_hold), 32'd1);
        chk("mid.rx_ready", 32'(bus.rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("mid.nwrites", 32'(wa_q.size()), 32'd10);
        if (wa_q.size() == 10) chk("mid.lastaddr", wa_q[9], 32'd9);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        s = {8'h02, 8'h00, 8'haa, 8'hbb};
        if (CHK_EN) s.push_back(8'haa ^ 8'hbb);
        run_case("restart", s, 0);

        // Empty image, followed by extra bytes that must be ignored.
        do_reset();
        s = {8'h00, 8'h00};
        if (CHK_EN) s.push_back(8'h00);
        s.push_back(8'h55);
        s.push_back(8'h66);
        run_case("empty", s, 2);

        // Largest legal image, random valid.
        do_reset();
        run_case("full", mk(DEPTH, 1'b1), 2);

        // One past the limit.
        do_reset();
        run_case("over1", mk(DEPTH + 1, 1'b1), 0);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        s = {8'h02, 8'h00, 8'h12, 8'h34, 8'h26};
        run_case("chk_ok", s, 0);
        do_reset();
        s = {8'h02, 8'h00, 8'h12, 8'h34, 8'h27};
        run_case("chk_bad", s, 0);
        do_reset();
        run_case("chk_rand_bad", mk(int'($urandom_range(1, DEPTH)), 1'b0), 2);
`endif

        // Random lengths and valid patterns.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            run_case($sformatf("rand%0d", t), mk(int'($urandom_range(1, DEPTH)), 1'b1), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
